microwave_timer_ctrl: RTL and testbench
=======================================

// Module: microwave_timer_ctrl
// PURPOSE
//   Sequencer for the cascaded BCD down-counter timer chain (min : sec_tens mod-6 : sec_ones).
//   Collects keypad digits and loads them into the chain. Gates the 1 Hz decrement enable.
//   Handles start/stop/door events, drives the magnetron enable and the end-of-cook "done" signal.
//   Sits between the keypad/button front end and the timer counters.
// PARAMETERS
//   NDIGITS     3  BCD digits in the timer chain (4 bits each)
//   DONE_HOLD   3  ticks that 'done' stays high after the count expires
//   SYNC_STAGES 2  synchroniser flops per pushbutton input
// PORTS
//   clock        in   1          system clock, all state on posedge
//   clear        in   1          asynchronous active-low reset
//   tick         in   1          1 Hz strobe, one clock wide
//   startn       in   1          start pushbutton, active-low, asynchronous
//   stopn        in   1          stop/cancel pushbutton, active-low, asynchronous
//   door_closed  in   1          1 = door closed (synchronous)
//   key_valid    in   1          one-cycle strobe: key_digit is valid
//   key_digit    in   4          BCD keypad digit
//   timer_zero   in   1          AND of all counter 'zero' flags
//   load_data    out  4*NDIGITS  digits to counters {min, sec_tens, sec_ones}
//   loadn        out  1          active-low one-cycle load strobe to counters
//   count_en     out  1          decrement enable to the counter chain
//   mag_on       out  1          magnetron enable
//   done         out  1          end-of-cook indicator
//   state        out  3          current FSM state (debug/display)
// BEHAVIOUR
//   Reset (clear=0): state=IDLE, load_data=0, loadn=1, count_en=0, mag_on=0, done=0, hold count=0.
//   Buttons: synchronised (SYNC_STAGES), falling edge -> one-cycle start_p/stop_p.
//     Button latency = SYNC_STAGES+1 cycles.
//   States: IDLE=0, LOAD=1, RUN=2, PAUSE=3, DONE=4, CANCEL=5.
//   IDLE: on key_valid with key_digit<=9, shift the digit into load_data from the right.
//       Old MSB digit is dropped. Digits >9 are ignored.
//     When the new digit lands in the sec_tens position and is >5, store 5.
//     start_p & door_closed & load_data!=0 -> LOAD.
//     Any other start_p -> ignored.
//     stop_p -> CANCEL.
//   LOAD: loadn=0 for exactly this cycle -> RUN next cycle.
//   RUN: mag_on=1. count_en = tick & ~timer_zero (combinational, same cycle as tick).
//     timer_zero -> DONE. The chain is never decremented at zero, so there is no wrap to 5/9.
//     stop_p or !door_closed -> PAUSE. count_en is suppressed in that same cycle, even if tick=1.
//   PAUSE: mag_on=0, count_en=0, counters hold.
//     start_p & door_closed -> RUN.
//     stop_p -> CANCEL.
//   DONE: done=1, mag_on=0. Hold counter counts ticks.
//     After DONE_HOLD ticks, or on stop_p -> IDLE.
//   CANCEL: load_data:=0, loadn=0 for one cycle (clears the chain) -> IDLE.
//   Simultaneous start_p & stop_p: stop wins in every state.
//   key_valid outside IDLE: ignored.
//   load_data keeps the entered time through RUN/PAUSE/DONE, so restart re-runs it.
//     It is cleared only in CANCEL.
//   clear asserted mid-run: all outputs take their reset values immediately (asynchronous).
// CONFIGURATION
//   QUICK_START_EN defined:
//     In IDLE, start_p & door_closed & load_data==0 sets load_data = 0:30 (0,3,0) -> LOAD.
//     In RUN, start_p adds 30 s: next tick is skipped, loadn pulses with (current+30) BCD,
//       saturating at 9:59.
//       Current time is taken from load_data tracking, i.e. the controller mirrors the count.
//   QUICK_START_EN undefined: zero-entry start is ignored; start_p in RUN is ignored.
// STRUCTURE
//   Package microwave_timer_pkg:
//     state enum/localparams; BCD_W=4; QUICK_ADD value {4'd0,4'd3,4'd0}; MAX_TIME {9,5,9}.
//   Sub-module button_sync_edge (SYNC_STAGES flops + falling-edge detect), instantiated for startn and stopn.
//   Counter chain stays outside this block.
// TESTING
//   1. Key 1,3,0; door closed; press start.
//      -> load_data=0x130; loadn low 1 cycle; RUN.
//      -> 90 count_en pulses on 90 ticks, then DONE. done high 3 ticks, then IDLE.
//   2. RUN at 0:45; open door on a tick cycle.
//      -> same cycle count_en=0; PAUSE; mag_on=0.
//      -> Close door, start: RUN resumes at 0:45.
//   3. Start and stop pressed in the same cycle during PAUSE.
//      -> CANCEL: loadn pulse with load_data=0, then IDLE.
//   4. Key 9 entered into sec_tens -> stored as 5.
//      Key 0xA -> no change. Start with entry 0 -> stays IDLE (macro off).
//   5. clear asserted mid-RUN -> all outputs 0 / loadn=1 asynchronously; IDLE after release.
//   6. QUICK_START_EN: start in IDLE with empty entry -> load 0x030, RUN.
//      Start at 9:45 -> reload 0x959.

Source files
------------

// File: rtl/microwave_timer_pkg.sv
// -----------------------------------------------------------------------------
// microwave_timer_pkg
//   Shared types and constants for the microwave timer controller.
//   - state_t    : controller FSM encoding (also exported on the debug port)
//   - BCD_W      : width of one BCD digit
//   - TIME_W     : width of the {min, sec_tens, sec_ones} time word
//   - QUICK_ADD  : 0:30, loaded or added by the quick-start feature
//   - MAX_TIME   : 9:59, the largest time the counter chain can hold
//   - bcd_dec    : one-second decrement of a time word (mod-6 tens digit)
//   - bcd_add_sat: time-word addition, saturating at MAX_TIME
// -----------------------------------------------------------------------------
package microwave_timer_pkg;

    localparam int BCD_W  = 4;
    localparam int TIME_W = 3 * BCD_W;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_PAUSE  = 3'd3,
        ST_DONE   = 3'd4,
        ST_CANCEL = 3'd5
    } state_t;

    localparam logic [TIME_W-1:0] QUICK_ADD = {4'd0, 4'd3, 4'd0};
    localparam logic [TIME_W-1:0] MAX_TIME  = {4'd9, 4'd5, 4'd9};

    // Decrement by one second; zero stays at zero (the chain never wraps).
    function automatic logic [TIME_W-1:0] bcd_dec(input logic [TIME_W-1:0] t);
        logic [3:0] m;
        logic [3:0] s10;
        logic [3:0] s1;
        m   = t[11:8];
        s10 = t[7:4];
        s1  = t[3:0];
        if (t == '0) begin
            return '0;
        end
        if (s1 != 4'd0) begin
            s1 = s1 - 4'd1;
        end else begin
            s1 = 4'd9;
            if (s10 != 4'd0) begin
                s10 = s10 - 4'd1;
            end else begin
                s10 = 4'd5;
                m   = m - 4'd1;
            end
        end
        return {m, s10, s1};
    endfunction

    // Digit-wise BCD add with a mod-6 tens digit; clamps to 9:59 on overflow.
    function automatic logic [TIME_W-1:0] bcd_add_sat(input logic [TIME_W-1:0] a,
                                                      input logic [TIME_W-1:0] b);
        logic [4:0] s1;
        logic [4:0] s10;
        logic [4:0] m;
        s1  = {1'b0, a[3:0]}  + {1'b0, b[3:0]};
        s10 = {1'b0, a[7:4]}  + {1'b0, b[7:4]};
        m   = {1'b0, a[11:8]} + {1'b0, b[11:8]};
        if (s1 > 5'd9) begin
            s1  = s1 - 5'd10;
            s10 = s10 + 5'd1;
        end
        if (s10 > 5'd5) begin
            s10 = s10 - 5'd6;
            m   = m + 5'd1;
        end
        if (m > 5'd9) begin
            return MAX_TIME;
        end
        return {m[3:0], s10[3:0], s1[3:0]};
    endfunction

endpackage

// File: rtl/button_sync_edge.sv
// -----------------------------------------------------------------------------
// button_sync_edge
//   Synchronises an asynchronous active-low pushbutton and emits a one-clock
//   pulse on its press (falling edge). Press-to-pulse-acted-on latency is
//   STAGES+1 clocks. STAGES must be at least 2.
// Ports
//   clock  : system clock
//   clear  : asynchronous active-low reset
//   btn_n  : raw active-low button
//   fall_p : one-cycle pulse, high the cycle after the synchronised press
// -----------------------------------------------------------------------------
module button_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic clear,
    input  logic btn_n,
    output logic fall_p
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // NOTE: reset the synchroniser to the released (high) level, otherwise the
    // first clock after reset would look like a press.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value and the chain shifts by exactly one stage.
            sync_q <= {sync_q[STAGES-2:0], btn_n};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign fall_p = prev_q & ~sync_q[STAGES-1];

endmodule

// File: rtl/microwave_timer_ctrl.sv
// -----------------------------------------------------------------------------
// microwave_timer_ctrl
//   Sequencer for the external cascaded BCD down-counter chain
//   {min, sec_tens (mod 6), sec_ones}. Collects keypad digits, loads them into
//   the chain, gates the 1 Hz decrement, handles start/stop/door and drives the
//   magnetron enable and the end-of-cook indicator.
// Optional feature: QUICK_START_EN (macro). When defined, start with an empty
//   entry loads 0:30, and start while running adds 30 s (saturating at 9:59),
//   skipping the next tick. The controller mirrors the running count for this.
//   The quick-start path assumes NDIGITS = 3.
// Ports
//   clock       : system clock, all state on posedge
//   clear       : asynchronous active-low reset
//   tick        : 1 Hz strobe, one clock wide
//   startn      : start button, active-low, asynchronous
//   stopn       : stop/cancel button, active-low, asynchronous
//   door_closed : 1 = door closed
//   key_valid   : key_digit valid strobe
//   key_digit   : BCD keypad digit
//   timer_zero  : AND of all counter zero flags
//   load_data   : digits to the counters {min, sec_tens, sec_ones}
//   loadn       : active-low one-cycle load strobe
//   count_en    : decrement enable to the chain
//   mag_on      : magnetron enable
//   done        : end-of-cook indicator
//   state       : current FSM state
// -----------------------------------------------------------------------------
module microwave_timer_ctrl
    import microwave_timer_pkg::*;
#(
    parameter int NDIGITS     = 3,
    parameter int DONE_HOLD   = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clock,
    input  logic                       clear,
    input  logic                       tick,
    input  logic                       startn,
    input  logic                       stopn,
    input  logic                       door_closed,
    input  logic                       key_valid,
    input  logic [BCD_W-1:0]           key_digit,
    input  logic                       timer_zero,
    output logic [BCD_W*NDIGITS-1:0]   load_data,
    output logic                       loadn,
    output logic                       count_en,
    output logic                       mag_on,
    output logic                       done,
    output logic [2:0]                 state
);

    localparam int DATA_W = BCD_W * NDIGITS;
    localparam int HOLD_W = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;

    state_t              cur_state;
    state_t              nxt_state;
    logic [DATA_W-1:0]   data_nxt;
    logic [DATA_W-1:0]   key_shift;
    logic [HOLD_W-1:0]   hold_q;
    logic [HOLD_W-1:0]   hold_nxt;
    logic                start_p;
    logic                stop_p;
    logic                pause_req;

`ifdef QUICK_START_EN
    logic [DATA_W-1:0]   mirror_q;
    logic [DATA_W-1:0]   mirror_nxt;
    logic                skip_q;
    logic                skip_nxt;
`endif

    assign state = cur_state;

    button_sync_edge #(.STAGES(SYNC_STAGES)) u_start_sync (
        .clock  (clock),
        .clear  (clear),
        .btn_n  (startn),
        .fall_p (start_p)
    );

    button_sync_edge #(.STAGES(SYNC_STAGES)) u_stop_sync (
        .clock  (clock),
        .clear  (clear),
        .btn_n  (stopn),
        .fall_p (stop_p)
    );

    // Shift the new digit in from the right; the digit moving into the
    // sec_tens slot is clamped to 5 so the entry is always a valid time.
    always_comb begin
        key_shift = {load_data[DATA_W-BCD_W-1:0], key_digit};
        if (key_shift[2*BCD_W-1:BCD_W] > 4'd5) begin
            key_shift[2*BCD_W-1:BCD_W] = 4'd5;
        end
    end

    // Stop wins over door and start; door opening pauses just like stop.
    assign pause_req = stop_p | ~door_closed;

    // ---------------- state register ----------------
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            cur_state <= ST_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // ---------------- next state / datapath next ----------------
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no
        // path through the case can leave one unassigned and infer a latch.
        nxt_state = cur_state;
        data_nxt  = load_data;
        hold_nxt  = '0;
`ifdef QUICK_START_EN
        mirror_nxt = mirror_q;
        skip_nxt   = skip_q;
`endif
        unique case (cur_state)
            ST_IDLE: begin
                if (stop_p) begin
                    nxt_state = ST_CANCEL;
                    data_nxt  = '0;
                end else if (start_p && door_closed && load_data != '0) begin
                    nxt_state = ST_LOAD;
`ifdef QUICK_START_EN
                    mirror_nxt = load_data;
                    skip_nxt   = 1'b0;
                end else if (start_p && door_closed) begin
                    nxt_state  = ST_LOAD;
                    data_nxt   = QUICK_ADD;
                    mirror_nxt = QUICK_ADD;
                    skip_nxt   = 1'b0;
`endif
                end else if (key_valid && key_digit <= 4'd9) begin
                    data_nxt = key_shift;
                end
            end
            ST_LOAD: begin
                nxt_state = ST_RUN;
            end
            ST_RUN: begin
`ifdef QUICK_START_EN
                if (count_en) begin
                    mirror_nxt = bcd_dec(mirror_q);
                end
                if (tick) begin
                    skip_nxt = 1'b0;
                end
`endif
                if (pause_req) begin
                    nxt_state = ST_PAUSE;
                end else if (timer_zero) begin
                    nxt_state = ST_DONE;
`ifdef QUICK_START_EN
                end else if (start_p) begin
                    nxt_state  = ST_LOAD;
                    data_nxt   = bcd_add_sat(mirror_q, QUICK_ADD);
                    mirror_nxt = bcd_add_sat(mirror_q, QUICK_ADD);
                    skip_nxt   = 1'b1;
`endif
                end
            end
            ST_PAUSE: begin
                if (stop_p) begin
                    nxt_state = ST_CANCEL;
                    data_nxt  = '0;
                end else if (start_p && door_closed) begin
                    nxt_state = ST_RUN;
                end
            end
            ST_DONE: begin
                hold_nxt = hold_q;
                if (stop_p) begin
                    nxt_state = ST_IDLE;
                end else if (tick) begin
                    if (hold_q == HOLD_W'(DONE_HOLD - 1)) begin
                        nxt_state = ST_IDLE;
                    end else begin
                        hold_nxt = hold_q + 1'b1;
                    end
                end
            end
            ST_CANCEL: begin
                nxt_state = ST_IDLE;
            end
            default: begin
                nxt_state = ST_IDLE;
            end
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            load_data <= '0;
            hold_q    <= '0;
`ifdef QUICK_START_EN
            mirror_q  <= '0;
            skip_q    <= 1'b0;
`endif
        end else begin
            load_data <= data_nxt;
            hold_q    <= hold_nxt;
`ifdef QUICK_START_EN
            mirror_q  <= mirror_nxt;
            skip_q    <= skip_nxt;
`endif
        end
    end

    // ---------------- outputs ----------------
    // All outputs decode the registered state, so an asynchronous clear
    // forces them to their idle values without waiting for a clock.
    always_comb begin
        loadn    = 1'b1;
        count_en = 1'b0;
        mag_on   = 1'b0;
        done     = 1'b0;
        unique case (cur_state)
            ST_LOAD, ST_CANCEL: begin
                loadn = 1'b0;
            end
            ST_RUN: begin
                mag_on = 1'b1;
                // Suppressed in the cycle a pause is requested and at zero.
`ifdef QUICK_START_EN
                count_en = tick & ~timer_zero & ~stop_p & door_closed & ~skip_q;
`else
                count_en = tick & ~timer_zero & ~stop_p & door_closed;
`endif
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_microwave_timer_ctrl
//   Self-checking bench for microwave_timer_ctrl. Includes a behavioural model
//   of the external BCD counter chain (driving timer_zero). Every expected load
//   word is pushed to exp_q when the button press is driven and popped when the
//   DUT pulses loadn. Honours QUICK_START_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_microwave_timer_ctrl;

    logic        clock;
    logic        clear;
    logic        tick;
    logic        startn;
    logic        stopn;
    logic        door_closed;
    logic        key_valid;
    logic [3:0]  key_digit;
    logic        timer_zero;
    logic [11:0] load_data;
    logic        loadn;
    logic        count_en;
    logic        mag_on;
    logic        done;
    logic [2:0]  state;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          ce_count = 0;
    int          zero_dec = 0;
    logic [11:0] chain;
    logic [11:0] exp_q[$];

    microwave_timer_ctrl dut (
        .clock       (clock),
        .clear       (clear),
        .tick        (tick),
        .startn      (startn),
        .stopn       (stopn),
        .door_closed (door_closed),
        .key_valid   (key_valid),
        .key_digit   (key_digit),
        .timer_zero  (timer_zero),
        .load_data   (load_data),
        .loadn       (loadn),
        .count_en    (count_en),
        .mag_on      (mag_on),
        .done        (done),
        .state       (state)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // ---- time word <-> seconds, written independently of the RTL ----
    function automatic int to_sec(input logic [11:0] t);
        return int'(t[11:8]) * 60 + int'(t[7:4]) * 10 + int'(t[3:0]);
    endfunction

    function automatic logic [11:0] to_bcd(input int s);
        return {4'(s / 60), 4'((s % 60) / 10), 4'(s % 10)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---- counter chain model ----
    always @(posedge clock or negedge clear) begin
        if (!clear) begin
            chain <= 12'h000;
        end else if (!loadn) begin
            chain <= load_data;
        end else if (count_en) begin
            if (chain == 12'h000) begin
                zero_dec <= zero_dec + 1;
            end else begin
                chain <= to_bcd(to_sec(chain) - 1);
            end
        end
    end

    assign timer_zero = (chain == 12'h000);

    // ---- scoreboard monitor: sampled on the falling edge ----
    always @(negedge clock) begin
        if (clear && !loadn) begin
            if (exp_q.size() == 0) begin
                check("loadn_unexpected", 32'(loadn), 32'd1);
            end else begin
                check("load_data_at_loadn", 32'(load_data), 32'(exp_q.pop_front()));
            end
        end
        if (count_en) begin
            ce_count++;
        end
    end

    // ---- stimulus helpers ----
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic key(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        step();
        key_valid = 1'b0;
        key_digit = 4'd0;
    endtask

    task automatic press(input logic do_start, input logic do_stop);
        if (do_start) startn = 1'b0;
        if (do_stop)  stopn  = 1'b0;
        repeat (4) step();
        startn = 1'b1;
        stopn  = 1'b1;
        repeat (2) step();
    endtask

    task automatic tick_pulse();
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
    endtask

    initial begin
        int ce0;
        int sec;
        logic [11:0] nxt;

        clear       = 1'b0;
        tick        = 1'b0;
        startn      = 1'b1;
        stopn       = 1'b1;
        door_closed = 1'b1;
        key_valid   = 1'b0;
        key_digit   = 4'd0;
        repeat (3) step();

        // ---- reset state ----
        check("rst_state",     32'(state),     32'd0);
        check("rst_load_data", 32'(load_data), 32'h000);
        check("rst_loadn",     32'(loadn),     32'd1);
        check("rst_count_en",  32'(count_en),  32'd0);
        check("rst_mag_on",    32'(mag_on),    32'd0);
        check("rst_done",      32'(done),      32'd0);
        clear = 1'b1;
        step();

        // ---- 1: 1:30 full cook ----
        key(4'd1); key(4'd3); key(4'd0);
        check("t1_entry", 32'(load_data), 32'h130);
        exp_q.push_back(12'h130);
        press(1'b1, 1'b0);
        check("t1_run", 32'(state), 32'd2);
        check("t1_mag_on", 32'(mag_on), 32'd1);
        ce0 = ce_count;
        for (int i = 0; i < 300; i++) begin
            if (state != 3'd2) break;
            tick_pulse();
        end
        check("t1_tick_count", 32'(ce_count - ce0), 32'd90);
        check("t1_state_done", 32'(state), 32'd4);
        check("t1_done", 32'(done), 32'd1);
        check("t1_mag_off", 32'(mag_on), 32'd0);
        check("t1_chain_zero", 32'(chain), 32'h000);
        tick_pulse();
        tick_pulse();
        check("t1_done_hold2", 32'(done), 32'd1);
        tick_pulse();
        check("t1_idle", 32'(state), 32'd0);
        check("t1_done_low", 32'(done), 32'd0);
        check("t1_keep_entry", 32'(load_data), 32'h130);

        // ---- 2: door opens on a tick cycle at 0:45 ----
        key(4'd0); key(4'd4); key(4'd5);
        check("t2_entry", 32'(load_data), 32'h045);
        exp_q.push_back(12'h045);
        press(1'b1, 1'b0);
        check("t2_run", 32'(state), 32'd2);
        check("t2_chain", 32'(chain), 32'h045);
        tick        = 1'b1;
        door_closed = 1'b0;
        @(negedge clock);
        check("t2_ce_suppressed", 32'(count_en), 32'd0);
        @(posedge clock);
        #1;
        tick = 1'b0;
        check("t2_pause", 32'(state), 32'd3);
        check("t2_mag_off", 32'(mag_on), 32'd0);
        step();
        check("t2_chain_hold", 32'(chain), 32'h045);
        door_closed = 1'b1;
        press(1'b1, 1'b0);
        check("t2_resume", 32'(state), 32'd2);
        check("t2_resume_chain", 32'(chain), 32'h045);
        tick_pulse();
        check("t2_after_tick", 32'(chain), 32'h044);

        // ---- 3: start and stop together in PAUSE ----
        press(1'b0, 1'b1);
        check("t3_pause", 32'(state), 32'd3);
        exp_q.push_back(12'h000);
        press(1'b1, 1'b1);
        check("t3_idle", 32'(state), 32'd0);
        check("t3_cleared", 32'(load_data), 32'h000);
        check("t3_chain_cleared", 32'(chain), 32'h000);

        // ---- 4: entry rules ----
        key(4'd1); key(4'd2); key(4'd3); key(4'd4);
        check("t4_msb_drop", 32'(load_data), 32'h234);
        key(4'd9); key(4'd0);
        check("t4_clamp_tens", 32'(load_data), 32'h450);
        key(4'hA);
        check("t4_ignore_A", 32'(load_data), 32'h450);
        exp_q.push_back(12'h000);
        press(1'b0, 1'b1);
        check("t4_cancel_idle", 32'(load_data), 32'h000);
`ifdef QUICK_START_EN
        exp_q.push_back(12'h030);
        press(1'b1, 1'b0);
        check("t4_quick_run", 32'(state), 32'd2);
        check("t4_quick_chain", 32'(chain), 32'h030);
        press(1'b0, 1'b1);
        exp_q.push_back(12'h000);
        press(1'b0, 1'b1);
        check("t4_quick_cancel", 32'(state), 32'd0);
`else
        press(1'b1, 1'b0);
        check("t4_zero_start_idle", 32'(state), 32'd0);
        check("t4_zero_start_data", 32'(load_data), 32'h000);
`endif

        // ---- 5: asynchronous clear mid-run ----
        key(4'd2); key(4'd3); key(4'd4);
        check("t5_entry", 32'(load_data), 32'h234);
        exp_q.push_back(12'h234);
        press(1'b1, 1'b0);
        tick_pulse();
        check("t5_chain", 32'(chain), 32'h233);
        tick = 1'b1;
        #1;
        check("t5_ce_before_clear", 32'(count_en), 32'd1);
        clear = 1'b0;
        #1;
        check("t5_clr_state", 32'(state), 32'd0);
        check("t5_clr_loadn", 32'(loadn), 32'd1);
        check("t5_clr_count_en", 32'(count_en), 32'd0);
        check("t5_clr_mag_on", 32'(mag_on), 32'd0);
        check("t5_clr_done", 32'(done), 32'd0);
        check("t5_clr_load_data", 32'(load_data), 32'h000);
        tick = 1'b0;
        step();
        clear = 1'b1;
        step();
        check("t5_idle_after", 32'(state), 32'd0);

`ifdef QUICK_START_EN
        // ---- 6: quick add while running, up to saturation ----
        key(4'd1); key(4'd5);
        exp_q.push_back(12'h015);
        press(1'b1, 1'b0);
        sec = 15;
        for (int k = 1; k <= 20; k++) begin
            nxt = (sec + 30 > 599) ? 12'h959 : to_bcd(sec + 30);
            exp_q.push_back(nxt);
            press(1'b1, 1'b0);
            sec = to_sec(nxt);
            if (k == 19) check("t6_at_945", 32'(load_data), 32'h945);
        end
        check("t6_saturated", 32'(load_data), 32'h959);
        check("t6_run", 32'(state), 32'd2);
        tick_pulse();
        check("t6_tick_skipped", 32'(chain), 32'h959);
        tick_pulse();
        check("t6_tick_counted", 32'(chain), 32'h958);
        press(1'b0, 1'b1);
        exp_q.push_back(12'h000);
        press(1'b0, 1'b1);
`endif

        repeat (4) step();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("no_dec_at_zero", 32'(zero_dec), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
